// File: rtl/gpu_wb_slave_ctrl.sv
// Wishbone slave front-end for the GPU register/memory space: region decode,
// programmable wait states, per-target back-pressure and error termination.
module gpu_wb_slave_ctrl #(
  parameter int ADDR_W       = 27,
  parameter int DATA_W       = 32,
  parameter int NUM_TGT      = 4,
  parameter int SEL_LSB      = 12,
  parameter int SEL_W        = 4,
  parameter int WAIT_CYCLES  = 1,
  parameter int DEFAULT_LAST = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [DATA_W/8-1:0]       wb_sel_i,
  input  logic [ADDR_W-1:0]         wb_adr_i,
  input  logic [DATA_W-1:0]         wb_dat_i,
  output logic [DATA_W-1:0]         wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic [NUM_TGT-1:0]        tgt_we_o,
  output logic [NUM_TGT-1:0]        tgt_re_o,
  output logic [ADDR_W-1:0]         tgt_addr_o,
  output logic [DATA_W-1:0]         tgt_wdata_o,
  output logic [DATA_W/8-1:0]       tgt_wsel_o,
  input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata_i,
  input  logic [NUM_TGT-1:0]        tgt_busy_i
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_CAPT, S_RESP, S_ERR} state_t;

  localparam logic [SEL_W:0]   NT_EXT   = (SEL_W+1)'(NUM_TGT);
  localparam logic [SEL_W-1:0] TGT_LAST = SEL_W'(NUM_TGT - 1);

  state_t              state, nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                capture;
  logic                we_q;
  logic [SEL_W-1:0]    tgt_q;
  logic [SEL_W-1:0]    tgt_raw;
  logic                in_range;
  logic                busy_sel;
  logic [DATA_W-1:0]   rd_sel;

  assign tgt_raw  = wb_adr_i[SEL_LSB +: SEL_W];
  assign in_range = {1'b0, tgt_raw} < NT_EXT;

  // Target-indexed busy and read-data selection for the latched region.
  always_comb begin
    busy_sel = 1'b0;
    rd_sel   = '0;
    for (int k = 0; k < NUM_TGT; k++) begin
      if (tgt_q == SEL_W'(k)) begin
        busy_sel = tgt_busy_i[k];
        rd_sel   = tgt_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Strobes are gated by reset so a pending issue never leaks out.
  always_comb begin
    tgt_we_o = '0;
    tgt_re_o = '0;
    if (state == S_ISSUE && !busy_sel && !reset) begin
      for (int k = 0; k < NUM_TGT; k++) begin
        if (tgt_q == SEL_W'(k)) begin
          tgt_we_o[k] = we_q;
          tgt_re_o[k] = !we_q;
        end
      end
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o) begin
          capture = 1'b1;
          if (!in_range && DEFAULT_LAST == 0) nxt = S_ERR;
          else if (WAIT_CYCLES == 0)          nxt = S_ISSUE;
          else begin
            nxt     = S_WAIT;
            cnt_nxt = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i)       nxt = S_IDLE;
        else if (cnt == 4'd1) nxt = S_ISSUE;
        else                 cnt_nxt = cnt - 4'd1;
      end
      S_ISSUE: begin
        if (busy_sel) begin
          if (!wb_cyc_i) nxt = S_IDLE;
        end else begin
          nxt = we_q ? S_RESP : S_CAPT;
        end
      end
      S_CAPT:  nxt = S_RESP;
      S_RESP:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      tgt_q       <= '0;
      tgt_addr_o  <= '0;
      tgt_wdata_o <= '0;
      tgt_wsel_o  <= '0;
      wb_dat_o    <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_nxt;
      // Ack is dropped if the master has already abandoned the cycle.
      wb_ack_o <= (nxt == S_RESP) && wb_cyc_i;
      wb_err_o <= (nxt == S_ERR);
      if (capture) begin
        we_q        <= wb_we_i;
        tgt_q       <= in_range ? tgt_raw : TGT_LAST;
        tgt_addr_o  <= wb_adr_i;
        tgt_wdata_o <= wb_dat_i;
        tgt_wsel_o  <= wb_sel_i;
      end
      if (state == S_CAPT) wb_dat_o <= rd_sel;
    end
  end

endmodule

// File: tb/tb_gpu_wb_slave_ctrl.sv
// Bench for gpu_wb_slave_ctrl: two instances (1 wait/default-last, 3 waits/error)
// checked every cycle against a per-cycle expectation schedule.
module tb_gpu_wb_slave_ctrl;
  localparam int AW = 27, DW = 32, NT = 4, MAXC = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  logic          cyc_i [2];
  logic          stb_i [2];
  logic          we_i  [2];
  logic [3:0]    sel_i [2];
  logic [AW-1:0] adr_i [2];
  logic [DW-1:0] dat_i [2];
  logic [DW-1:0] dat_o [2];
  logic          ack_o [2];
  logic          err_o [2];
  logic [NT-1:0] we_o  [2];
  logic [NT-1:0] re_o  [2];
  logic [AW-1:0] addr_o[2];
  logic [DW-1:0] wd_o  [2];
  logic [3:0]    ws_o  [2];
  logic [NT-1:0] busy_i[2];
  logic [NT*DW-1:0] rdata = {32'h12345678, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

  gpu_wb_slave_ctrl #(.WAIT_CYCLES(1), .DEFAULT_LAST(1)) u_a (
    .clk(clk), .reset(reset), .wb_cyc_i(cyc_i[0]), .wb_stb_i(stb_i[0]), .wb_we_i(we_i[0]),
    .wb_sel_i(sel_i[0]), .wb_adr_i(adr_i[0]), .wb_dat_i(dat_i[0]), .wb_dat_o(dat_o[0]),
    .wb_ack_o(ack_o[0]), .wb_err_o(err_o[0]), .tgt_we_o(we_o[0]), .tgt_re_o(re_o[0]),
    .tgt_addr_o(addr_o[0]), .tgt_wdata_o(wd_o[0]), .tgt_wsel_o(ws_o[0]),
    .tgt_rdata_i(rdata), .tgt_busy_i(busy_i[0]));

  gpu_wb_slave_ctrl #(.WAIT_CYCLES(3), .DEFAULT_LAST(0)) u_b (
    .clk(clk), .reset(reset), .wb_cyc_i(cyc_i[1]), .wb_stb_i(stb_i[1]), .wb_we_i(we_i[1]),
    .wb_sel_i(sel_i[1]), .wb_adr_i(adr_i[1]), .wb_dat_i(dat_i[1]), .wb_dat_o(dat_o[1]),
    .wb_ack_o(ack_o[1]), .wb_err_o(err_o[1]), .tgt_we_o(we_o[1]), .tgt_re_o(re_o[1]),
    .tgt_addr_o(addr_o[1]), .tgt_wdata_o(wd_o[1]), .tgt_wsel_o(ws_o[1]),
    .tgt_rdata_i(rdata), .tgt_busy_i(busy_i[1]));

  // Expected outputs per instance per cycle; everything defaults to zero.
  logic [NT-1:0] ex_we [2][MAXC];
  logic [NT-1:0] ex_re [2][MAXC];
  logic          ex_ack[2][MAXC];
  logic          ex_err[2][MAXC];
  logic [AW-1:0] ex_adr[2][MAXC];
  logic [DW-1:0] ex_wd [2][MAXC];
  logic [3:0]    ex_ws [2][MAXC];
  logic [DW-1:0] ex_dat[2][MAXC];

  int n_cmp = 0, n_bad = 0;
  int stb_at[2], ack_at[2], err_at[2];
  logic [DW-1:0] dat_at_ack[2];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d cyc=%0d: got %h want %h", nm, i, cyc_n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc_n >= 1 && cyc_n < MAXC) begin
      for (int i = 0; i < 2; i++) begin
        chk("tgt_we",    i, 32'(we_o[i]),   32'(ex_we[i][cyc_n]));
        chk("tgt_re",    i, 32'(re_o[i]),   32'(ex_re[i][cyc_n]));
        chk("wb_ack",    i, 32'(ack_o[i]),  32'(ex_ack[i][cyc_n]));
        chk("wb_err",    i, 32'(err_o[i]),  32'(ex_err[i][cyc_n]));
        chk("tgt_addr",  i, 32'(addr_o[i]), 32'(ex_adr[i][cyc_n]));
        chk("tgt_wdata", i, wd_o[i],        ex_wd[i][cyc_n]);
        chk("tgt_wsel",  i, 32'(ws_o[i]),   32'(ex_ws[i][cyc_n]));
        chk("wb_dat",    i, dat_o[i],       ex_dat[i][cyc_n]);
        if (ack_o[i] === 1'b1) begin ack_at[i] = cyc_n; dat_at_ack[i] = dat_o[i]; end
        if (err_o[i] === 1'b1) err_at[i] = cyc_n;
        if ((we_o[i] | re_o[i]) != 4'd0) stb_at[i] = cyc_n;
      end
    end
  end

  task automatic next(); @(posedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) next(); endtask

  task automatic fill(input int i, input int from, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [3:0] s);
    for (int c = from; c < MAXC; c++) begin ex_adr[i][c] = a; ex_wd[i][c] = d; ex_ws[i][c] = s; end
  endtask

  task automatic fill_dat(input int i, input int from, input logic [DW-1:0] d);
    for (int c = from; c < MAXC; c++) ex_dat[i][c] = d;
  endtask

  task automatic drive(input int i, input logic on, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] s);
    cyc_i[i] = on; stb_i[i] = on; we_i[i] = w; adr_i[i] = a; dat_i[i] = d; sel_i[i] = s;
  endtask

  // One complete transaction starting this cycle; nb = cycles the target reports busy in issue.
  task automatic txn(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [3:0] s, input int nb);
    int c0, f, t, st, ak, wt, bs;
    bit er;
    wt = (i == 0) ? 1 : 3;
    c0 = cyc_n;
    f  = int'(a[15:12]);
    t  = f;
    er = 1'b0;
    if (f >= NT) begin
      if (i == 0) t = NT - 1; else er = 1'b1;
    end
    fill(i, c0 + 1, a, d, s);
    bs = c0 + wt + 1;
    if (er) begin
      ex_err[i][c0 + 1] = 1'b1;
      ak = c0 + 1;
    end else begin
      st = bs + nb;
      if (w) ex_we[i][st][t] = 1'b1; else ex_re[i][st][t] = 1'b1;
      ak = w ? st + 1 : st + 2;
      ex_ack[i][ak] = 1'b1;
      if (!w) fill_dat(i, ak, rdata[t*DW +: DW]);
    end
    drive(i, 1'b1, w, a, d, s);
    while (cyc_n <= ak) begin
      busy_i[i] = '0;
      if (!er && cyc_n >= bs && cyc_n < bs + nb) busy_i[i][t] = 1'b1;
      next();
    end
    busy_i[i] = '0;
    drive(i, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 1'b0, '0, '0, '0);
      busy_i[i] = '0;
      stb_at[i] = -100; ack_at[i] = -100; err_at[i] = -100; dat_at_ack[i] = '0;
      for (int c = 0; c < MAXC; c++) begin
        ex_we[i][c] = '0; ex_re[i][c] = '0; ex_ack[i][c] = 1'b0; ex_err[i][c] = 1'b0;
        ex_adr[i][c] = '0; ex_wd[i][c] = '0; ex_ws[i][c] = '0; ex_dat[i][c] = '0;
      end
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Write to region 1, one wait state
    c0 = cyc_n; txn(0, 1'b1, 27'h0_1004, 32'hDEADBEEF, 4'hF, 0);
    chk("wr_stb_lat", 0, 32'(stb_at[0] - c0), 32'd2);
    chk("wr_ack_lat", 0, 32'(ack_at[0] - c0), 32'd3);
    idle(2);

    // Read region 3, then a back-to-back write to unmapped select 9 (clamps to 3)
    c0 = cyc_n; txn(0, 1'b0, 27'h0_3010, 32'h0, 4'hF, 0);
    chk("rd_stb_lat", 0, 32'(stb_at[0] - c0), 32'd2);
    chk("rd_ack_lat", 0, 32'(ack_at[0] - c0), 32'd4);
    chk("rd_data",    0, dat_at_ack[0], 32'h12345678);
    c0 = cyc_n; txn(0, 1'b1, 27'h0_9000, 32'hA5A50009, 4'h3, 0);
    chk("b2b_stb_lat", 0, 32'(stb_at[0] - c0), 32'd2);
    idle(2);

    // Target 0 busy for five issue cycles
    c0 = cyc_n; txn(0, 1'b1, 27'h0_0100, 32'h0BADF00D, 4'h5, 5);
    chk("busy_stb_lat", 0, 32'(stb_at[0] - c0), 32'd7);
    chk("busy_ack_lat", 0, 32'(ack_at[0] - c0), 32'd8);
    idle(2);

    // Unmapped select on the error-responding instance
    c0 = cyc_n; txn(1, 1'b1, 27'h0_9000, 32'h99990000, 4'hF, 0);
    chk("err_lat", 1, 32'(err_at[1] - c0), 32'd1);
    idle(2);

    // Master abandons the cycle during wait states
    c0 = cyc_n;
    fill(1, c0 + 1, 27'h0_2040, 32'h11112222, 4'hF);
    drive(1, 1'b1, 1'b1, 27'h0_2040, 32'h11112222, 4'hF);
    idle(2);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    idle(6);
    c0 = cyc_n; txn(1, 1'b0, 27'h0_1000, 32'h0, 4'hF, 0);
    chk("rd3_stb_lat", 1, 32'(stb_at[1] - c0), 32'd4);
    chk("rd3_ack_lat", 1, 32'(ack_at[1] - c0), 32'd6);
    chk("rd3_data",    1, dat_at_ack[1], 32'hCAFE0001);
    idle(2);

    // Reset during a busy-stalled issue
    c0 = cyc_n;
    fill(0, c0 + 1, 27'h0_0020, 32'h55AA55AA, 4'hC);
    for (int i = 0; i < 2; i++) begin fill(i, c0 + 3, '0, '0, '0); fill_dat(i, c0 + 3, '0); end
    drive(0, 1'b1, 1'b1, 27'h0_0020, 32'h55AA55AA, 4'hC);
    busy_i[0] = 4'b0001;
    idle(2);
    reset = 1'b1;
    next();
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    idle(2);
    busy_i[0] = '0;
    idle(4);

    // Service resumes normally after reset
    c0 = cyc_n; txn(0, 1'b0, 27'h0_2000, 32'h0, 4'hF, 0);
    chk("post_rst_data", 0, dat_at_ack[0], 32'hCAFE0002);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
